// File: rtl/mul_cell_pipe.sv
// Three-stage sliced integer multiplier (MUL / MULXUU / MULXSU / MULXSS) with tag sideband.
// Builds the full 2*DATA_W product from SLICE_W x SLICE_W unsigned partial products plus sign correction.
module mul_cell_pipe #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NS  = DATA_W / SLICE_W;
  localparam int NPP = NS * NS;
  localparam int PW  = 2 * DATA_W;
  localparam int SW2 = 2 * SLICE_W;

  generate
    if ((DATA_W % SLICE_W) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_param
      $error("mul_cell_pipe: DATA_W must be a multiple of SLICE_W within 8..64");
    end
  endgenerate

  function automatic logic [SW2-1:0] slice_mul(input logic [SLICE_W-1:0] a,
                                               input logic [SLICE_W-1:0] b);
    return {{SLICE_W{1'b0}}, a} * {{SLICE_W{1'b0}}, b};
  endfunction

  // MUL returns the low half; every MULX variant returns the high half.
  function automatic logic [DATA_W-1:0] select_half(input logic [PW-1:0] p,
                                                    input logic [1:0]    op);
    return (op == 2'b00) ? p[DATA_W-1:0] : p[PW-1:DATA_W];
  endfunction

  logic [SW2-1:0]    pp_p1 [NPP];
  logic [DATA_W-1:0] a_p1, b_p1;
  logic              neg_a_p1, neg_b_p1;
  logic [1:0]        op_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic              vld_p1;

  logic [PW-1:0]     sum_p1;
  logic [PW-1:0]     term_p1;

  logic [PW-1:0]     prod_p2;
  logic [1:0]        op_p2;
  logic [TAG_W-1:0]  tag_p2;
  logic              vld_p2;

  logic [DATA_W-1:0] res_p3;
  logic [TAG_W-1:0]  tag_p3;
  logic              vld_p3;

  // Stage 1: unsigned slice products and sign-correction flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NPP; k++) pp_p1[k] <= '0;
      a_p1     <= '0;
      b_p1     <= '0;
      neg_a_p1 <= 1'b0;
      neg_b_p1 <= 1'b0;
      op_p1    <= '0;
      tag_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (flush)   vld_p1 <= 1'b0;
      else if (en) vld_p1 <= in_valid;
      if (en) begin
        for (int i = 0; i < NS; i++)
          for (int j = 0; j < NS; j++)
            pp_p1[i*NS+j] <= slice_mul(in_src1[i*SLICE_W +: SLICE_W],
                                       in_src2[j*SLICE_W +: SLICE_W]);
        a_p1     <= in_src1;
        b_p1     <= in_src2;
        neg_a_p1 <= in_op[1] & in_src1[DATA_W-1];
        neg_b_p1 <= (in_op == 2'b11) & in_src2[DATA_W-1];
        op_p1    <= in_op;
        tag_p1   <= in_tag;
      end
    end
  end

  // A negative signed operand contributes its unsigned value minus 2^DATA_W,
  // so the cross term -(other << DATA_W) is removed modulo 2^(2*DATA_W).
  always_comb begin
    sum_p1  = '0;
    term_p1 = '0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++) begin
        term_p1            = '0;
        term_p1[SW2-1:0]   = pp_p1[i*NS+j];
        sum_p1             = sum_p1 + (term_p1 << ((i + j) * SLICE_W));
      end
    if (neg_a_p1) sum_p1 = sum_p1 - {b_p1, {DATA_W{1'b0}}};
    if (neg_b_p1) sum_p1 = sum_p1 - {a_p1, {DATA_W{1'b0}}};
  end

  // Stage 2: full-width corrected product
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_p2 <= '0;
      op_p2   <= '0;
      tag_p2  <= '0;
      vld_p2  <= 1'b0;
    end else begin
      if (flush)   vld_p2 <= 1'b0;
      else if (en) vld_p2 <= vld_p1;
      if (en) begin
        prod_p2 <= sum_p1;
        op_p2   <= op_p1;
        tag_p2  <= tag_p1;
      end
    end
  end

  // Stage 3: half select into the output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      res_p3 <= '0;
      tag_p3 <= '0;
      vld_p3 <= 1'b0;
    end else begin
      if (flush)   vld_p3 <= 1'b0;
      else if (en) vld_p3 <= vld_p2;
      if (en) begin
        res_p3 <= select_half(prod_p2, op_p2);
        tag_p3 <= tag_p2;
      end
    end
  end

  assign out_valid  = vld_p3;
  assign out_result = res_p3;
  assign out_tag    = tag_p3;

endmodule

// File: tb/tb_mul_cell_pipe.sv
// Scoreboard bench for mul_cell_pipe: a 32/16 instance and a 16/8 instance share one stimulus
// stream; expected results come from a signed/unsigned arithmetic model.
module tb_mul_cell_pipe;

  logic        clk = 1'b0;
  logic        reset, en, flush, in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_tag;

  logic        v32, v16;
  logic [31:0] r32;
  logic [15:0] r16;
  logic [4:0]  t32, t16;

  always #5 clk = ~clk;

  mul_cell_pipe #(.DATA_W(32), .SLICE_W(16), .TAG_W(5)) u_dut32 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(v32), .out_result(r32), .out_tag(t32));

  mul_cell_pipe #(.DATA_W(16), .SLICE_W(8), .TAG_W(5)) u_dut16 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_src1(in_src1[15:0]), .in_src2(in_src2[15:0]), .in_tag(in_tag),
    .out_valid(v16), .out_result(r16), .out_tag(t16));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cnt;
  } exp_t;

  exp_t q[2][$];
  int   checks = 0;
  int   errors = 0;
  int   adv_cnt = 0;

  logic        v_o [2];
  logic [31:0] r_o [2];
  logic [4:0]  t_o [2];
  assign v_o[0] = v32;
  assign v_o[1] = v16;
  assign r_o[0] = r32;
  assign r_o[1] = {16'h0, r16};
  assign t_o[0] = t32;
  assign t_o[1] = t16;

  // Reference: interpret operands per op, multiply exactly, pick the half.
  function automatic logic [31:0] ref_mul(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint ma, sa, sb, p;
    ma = (longint'(1) << w) - 1;
    sa = longint'(a) & ma;
    sb = longint'(b) & ma;
    if (op[1] && sa[w-1]) sa = sa - (longint'(1) << w);
    if (op == 2'b11 && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return (op == 2'b00) ? 32'(p & ma) : 32'((p >>> w) & ma);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: retire expectations on reset/flush, then check outputs after each edge.
  logic        sv [2] = '{1'b0, 1'b0};
  logic [31:0] sr [2] = '{32'h0, 32'h0};
  logic [4:0]  st [2] = '{5'h0, 5'h0};
  logic        s_en, s_rst, s_fl;

  always begin
    exp_t e;
    @(posedge clk);
    s_en = en; s_rst = reset; s_fl = flush;
    if (s_rst || s_fl) begin
      q[0].delete();
      q[1].delete();
    end
    if (!s_rst && s_en) adv_cnt++;
    #2;
    for (int k = 0; k < 2; k++) begin
      if (s_rst) begin
        chk($sformatf("reset_valid_d%0d", k), {31'h0, v_o[k]}, 32'h0);
        chk($sformatf("reset_result_d%0d", k), r_o[k], 32'h0);
        chk($sformatf("reset_tag_d%0d", k), {27'h0, t_o[k]}, 32'h0);
      end else if (s_fl) begin
        chk($sformatf("flush_valid_d%0d", k), {31'h0, v_o[k]}, 32'h0);
      end else if (!s_en) begin
        chk($sformatf("hold_valid_d%0d", k), {31'h0, v_o[k]}, {31'h0, sv[k]});
        chk($sformatf("hold_result_d%0d", k), r_o[k], sr[k]);
        chk($sformatf("hold_tag_d%0d", k), {27'h0, t_o[k]}, {27'h0, st[k]});
      end else if (v_o[k]) begin
        if (q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output_d%0d actual=%h required=no_output", k, r_o[k]);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("result_d%0d", k), r_o[k], e.res);
          chk($sformatf("tag_d%0d", k), {27'h0, t_o[k]}, {27'h0, e.tag});
          chk($sformatf("latency_d%0d", k), adv_cnt, e.cnt + 3);
        end
      end
      sv[k] = v_o[k];
      sr[k] = r_o[k];
      st[k] = t_o[k];
    end
  end

  task automatic step(logic e, logic v, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                      logic [4:0] tag, logic fl, logic rs,
                      logic use_k, logic [31:0] k32, logic [15:0] k16);
    exp_t x, y;
    en = e; in_valid = v; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    flush = fl; reset = rs;
    if (e && v && !fl && !rs) begin
      x.res = use_k ? k32 : ref_mul(32, op, a, b);
      x.tag = tag; x.cnt = adv_cnt;
      y.res = use_k ? {16'h0, k16} : ref_mul(16, op, a, b);
      y.tag = tag; y.cnt = adv_cnt;
      q[0].push_back(x);
      q[1].push_back(y);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op_k(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag,
                      logic [31:0] k32, logic [15:0] k16);
    step(1'b1, 1'b1, op, a, b, tag, 1'b0, 1'b0, 1'b1, k32, k16);
  endtask

  task automatic op_m(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
    step(1'b1, 1'b1, op, a, b, tag, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic idle(int n, logic e);
    for (int i = 0; i < n; i++)
      step(e, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0:       r = 32'h0;
      1:       r = 32'hFFFF_FFFF;
      2:       r = 32'h8000_0000;
      3:       r = 32'h0000_8000;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  initial begin
    step(1'b1, 1'b1, 2'b11, 32'h1234, 32'h5678, 5'h1F, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0);
    step(1'b1, 1'b1, 2'b00, 32'h1, 32'h1, 5'h3, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0);
    idle(2, 1'b1);

    // All-ones operands through every op, back to back
    op_k(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 16'h0001);
    op_k(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 16'hFFFE);
    op_k(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 16'hFFFF);
    op_k(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 16'h0000);
    // Most-negative operand corner cases
    op_k(2'b11, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 16'h0000);
    op_k(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h0000_0000, 16'h0000);
    op_k(2'b10, 32'h8000_0000, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF, 16'h0000);
    op_k(2'b00, 32'h0000_1234, 32'h0000_5678, 5'd8, 32'h0626_0060, 16'h0060);
    op_k(2'b01, 32'h0000_1234, 32'h0000_5678, 5'd9, 32'h0000_0000, 16'h0626);
    idle(5, 1'b1);

    // Stall after the second issue
    op_m(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd10);
    op_m(2'b10, 32'hCAFE_F00D, 32'h8765_4321, 5'd11);
    step(1'b0, 1'b1, 2'b01, 32'h5, 32'h7, 5'd30, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    idle(3, 1'b0);
    op_m(2'b01, 32'hFEDC_BA98, 32'h0F0F_0F0F, 5'd12);
    idle(5, 1'b1);

    // Flush with a coinciding issue, then a fresh op
    op_m(2'b00, 32'h1111_1111, 32'h2222_2222, 5'd13);
    op_m(2'b11, 32'h9999_9999, 32'h3333_3333, 5'd14);
    step(1'b1, 1'b1, 2'b01, 32'h4444_4444, 32'h5555_5555, 5'd15, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0);
    op_m(2'b10, 32'hF000_0001, 32'h0000_0003, 5'd16);
    idle(5, 1'b1);

    // Reset mid-stream while stalled and flushing
    op_m(2'b00, 32'h7777_7777, 32'h6666_6666, 5'd17);
    op_m(2'b01, 32'hABCD_EF01, 32'h2345_6789, 5'd18);
    op_m(2'b11, 32'h8000_0001, 32'hFFFF_FFFE, 5'd19);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0);
    idle(6, 1'b1);

    // Randomised traffic with stalls, bubbles and occasional flushes
    for (int n = 0; n < 20000; n++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
           5'($urandom_range(0, 31)), ($urandom_range(0, 99) == 0), 1'b0,
           1'b0, 32'h0, 16'h0);
    end
    idle(10, 1'b1);

    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL drain_d%0d actual=%0d pending required=0 pending", k, q[k].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
